// File: rtl/nand_pkg.sv
// rtl/nand_pkg.sv - shared FSM encoding, ONFI opcodes and helpers for the NAND command sequencer
package nand_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CE_SETUP,
        ST_CMD1,
        ST_ADDR,
        ST_CMD2,
        ST_WB,
        ST_BUSY_WAIT,
        ST_DONE
    } seq_state_t;

    localparam logic [7:0] OP_RESET       = 8'hFF;
    localparam logic [7:0] OP_READ1       = 8'h00;
    localparam logic [7:0] OP_READ2       = 8'h30;
    localparam logic [7:0] OP_PROG1       = 8'h80;
    localparam logic [7:0] OP_PROG2       = 8'h10;
    localparam logic [7:0] OP_ERASE1      = 8'h60;
    localparam logic [7:0] OP_ERASE2      = 8'hD0;
    localparam logic [7:0] OP_READ_STATUS = 8'h70;

    localparam logic [2:0] MAX_ADDR_BYTES = 3'd5;

    function automatic logic [2:0] clamp_naddr(input logic [2:0] n);
        return (n > MAX_ADDR_BYTES) ? MAX_ADDR_BYTES : n;
    endfunction

endpackage

// File: rtl/nand_sync2.sv
// rtl/nand_sync2.sv - 4-bit two-flop synchronizer for the raw R/B# lines, resets to not-busy
module nand_sync2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nand_cmd_seq.sv
// rtl/nand_cmd_seq.sv - NAND command/address sequencer: CE setup, CLE/ALE byte latching, R/B# wait
module nand_cmd_seq
    import nand_pkg::*;
#(
    parameter int T_CS    = 2,
    parameter int T_CYC   = 1,
    parameter int T_WB    = 10,
    parameter int TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_chip,
    input  logic [7:0]  req_cmd1,
    input  logic [2:0]  req_naddr,
    input  logic [39:0] req_addr,
    input  logic        req_has_cmd2,
    input  logic [7:0]  req_cmd2,
    input  logic        req_wait_rb,
    input  logic [3:0]  rb_n,
    output logic [1:0]  cen,
    output logic        cle,
    output logic        ale,
    output logic        wrn,
    output logic        wpn,
    output logic [7:0]  dq_out,
    output logic        dq_oe,
    output logic        done_valid,
    output logic        done_timeout
);

    localparam int HOLD_MAX = (T_CS > T_CYC) ? ((T_CS > T_WB) ? T_CS : T_WB)
                                             : ((T_CYC > T_WB) ? T_CYC : T_WB);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int WAIT_W   = $clog2(TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] CS_LOAD   = HOLD_W'(T_CS - 1);
    localparam logic [HOLD_W-1:0] CYC_LOAD  = HOLD_W'(T_CYC - 1);
    localparam logic [HOLD_W-1:0] WB_LOAD   = HOLD_W'(T_WB - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

    seq_state_t        state, nxt_state;
    logic [HOLD_W-1:0] hold, nxt_hold;
    logic [2:0]        byte_idx, nxt_byte;
    logic [WAIT_W-1:0] wait_cnt, nxt_wait;
    logic              nxt_timeout;
    logic              go_post_addr, go_post_bytes;

    logic              chip_q;
    logic [7:0]        cmd1_q, cmd2_q;
    logic [2:0]        naddr_q;
    logic [39:0]       addr_q;
    logic              has_cmd2_q, wait_rb_q;
    logic [3:0]        rb_sync;
    logic              sel_chip;

    nand_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rb_n),
        .q     (rb_sync)
    );

    assign wrn      = 1'b1;
    assign sel_chip = (state == ST_IDLE) ? req_chip : chip_q;

    // Every hold-timed state loads hold with (duration-1) on entry and leaves at zero.
    always_comb begin
        nxt_state     = state;
        nxt_hold      = hold;
        nxt_byte      = byte_idx;
        nxt_wait      = wait_cnt;
        nxt_timeout   = 1'b0;
        go_post_addr  = 1'b0;
        go_post_bytes = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    nxt_state = ST_CE_SETUP;
                    nxt_hold  = CS_LOAD;
                end
            end
            ST_CE_SETUP: begin
                if (hold == '0) begin
                    nxt_state = ST_CMD1;
                    nxt_hold  = CYC_LOAD;
                end else begin
                    nxt_hold = hold - 1'b1;
                end
            end
            ST_CMD1: begin
                if (hold != '0) begin
                    nxt_hold = hold - 1'b1;
                end else if (naddr_q != 3'd0) begin
                    nxt_state = ST_ADDR;
                    nxt_hold  = CYC_LOAD;
                    nxt_byte  = 3'd0;
                end else begin
                    go_post_addr = 1'b1;
                end
            end
            ST_ADDR: begin
                if (hold != '0) begin
                    nxt_hold = hold - 1'b1;
                end else if (byte_idx == naddr_q - 3'd1) begin
                    go_post_addr = 1'b1;
                end else begin
                    nxt_byte = byte_idx + 3'd1;
                    nxt_hold = CYC_LOAD;
                end
            end
            ST_CMD2: begin
                if (hold != '0) nxt_hold = hold - 1'b1;
                else            go_post_bytes = 1'b1;
            end
            ST_WB: begin
                if (hold != '0) begin
                    nxt_hold = hold - 1'b1;
                end else begin
                    nxt_state = ST_BUSY_WAIT;
                    nxt_wait  = '0;
                end
            end
            ST_BUSY_WAIT: begin
                if (rb_sync[{1'b0, chip_q}]) begin
                    nxt_state = ST_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    nxt_state   = ST_DONE;
                    nxt_timeout = 1'b1;
                end else if (wait_cnt != WAIT_MAX) begin
                    nxt_wait = wait_cnt + 1'b1;
                end
            end
            ST_DONE:  nxt_state = ST_IDLE;
            default:  nxt_state = ST_IDLE;
        endcase

        if (go_post_addr) begin
            if (has_cmd2_q) begin
                nxt_state = ST_CMD2;
                nxt_hold  = CYC_LOAD;
            end else begin
                go_post_bytes = 1'b1;
            end
        end
        if (go_post_bytes) begin
            if (wait_rb_q) begin
                nxt_state = ST_WB;
                nxt_hold  = WB_LOAD;
            end else begin
                nxt_state = ST_DONE;
            end
        end
    end

    // Pin outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            hold         <= '0;
            byte_idx     <= 3'd0;
            wait_cnt     <= '0;
            chip_q       <= 1'b0;
            cmd1_q       <= 8'h00;
            cmd2_q       <= 8'h00;
            naddr_q      <= 3'd0;
            addr_q       <= 40'h0;
            has_cmd2_q   <= 1'b0;
            wait_rb_q    <= 1'b0;
            req_ready    <= 1'b1;
            cen          <= 2'b11;
            cle          <= 1'b0;
            ale          <= 1'b0;
            wpn          <= 1'b0;
            dq_out       <= 8'h00;
            dq_oe        <= 1'b0;
            done_valid   <= 1'b0;
            done_timeout <= 1'b0;
        end else begin
            state    <= nxt_state;
            hold     <= nxt_hold;
            byte_idx <= nxt_byte;
            wait_cnt <= nxt_wait;
            wpn      <= 1'b1;

            if (state == ST_IDLE && req_valid) begin
                chip_q     <= req_chip;
                cmd1_q     <= req_cmd1;
                cmd2_q     <= req_cmd2;
                naddr_q    <= clamp_naddr(req_naddr);
                addr_q     <= req_addr;
                has_cmd2_q <= req_has_cmd2;
                wait_rb_q  <= req_wait_rb;
            end

            req_ready    <= (nxt_state == ST_IDLE);
            done_valid   <= (nxt_state == ST_DONE);
            done_timeout <= nxt_timeout;

            cen <= 2'b11;
            if (nxt_state != ST_IDLE && nxt_state != ST_DONE) cen[sel_chip] <= 1'b0;

            cle   <= (nxt_state == ST_CMD1) || (nxt_state == ST_CMD2);
            ale   <= (nxt_state == ST_ADDR);
            dq_oe <= (nxt_state == ST_CMD1) || (nxt_state == ST_CMD2) || (nxt_state == ST_ADDR);
            case (nxt_state)
                ST_CMD1: dq_out <= cmd1_q;
                ST_ADDR: dq_out <= addr_q[{nxt_byte, 3'b000} +: 8];
                ST_CMD2: dq_out <= cmd2_q;
                default: dq_out <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_cmd_seq.sv
// tb/tb_nand_cmd_seq.sv - randomized bench for nand_cmd_seq against a per-cycle timeline model
module tb_nand_cmd_seq;
    import nand_pkg::*;

    localparam int A_CS = 2, A_CYC = 1, A_WB = 10, A_TO = 1048576;
    localparam int B_CS = 1, B_CYC = 3, B_WB = 3,  B_TO = 64;
    localparam int NEVER = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_chip = 1'b0;
    logic [7:0]  req_cmd1 = 8'h00;
    logic [2:0]  req_naddr = 3'd0;
    logic [39:0] req_addr = 40'h0;
    logic        req_has_cmd2 = 1'b0;
    logic [7:0]  req_cmd2 = 8'h00;
    logic        req_wait_rb = 1'b0;
    logic [3:0]  rb_n = 4'hF;

    logic       ready_a, cle_a, ale_a, wrn_a, wpn_a, oe_a, dv_a, dt_a;
    logic       ready_b, cle_b, ale_b, wrn_b, wpn_b, oe_b, dv_b, dt_b;
    logic [1:0] cen_a, cen_b;
    logic [7:0] dq_a, dq_b;
    logic [17:0] obs_a, obs_b, obs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nand_cmd_seq #(.T_CS(A_CS), .T_CYC(A_CYC), .T_WB(A_WB), .TIMEOUT(A_TO)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(ready_a),
        .req_chip(req_chip), .req_cmd1(req_cmd1), .req_naddr(req_naddr), .req_addr(req_addr),
        .req_has_cmd2(req_has_cmd2), .req_cmd2(req_cmd2), .req_wait_rb(req_wait_rb), .rb_n(rb_n),
        .cen(cen_a), .cle(cle_a), .ale(ale_a), .wrn(wrn_a), .wpn(wpn_a), .dq_out(dq_a),
        .dq_oe(oe_a), .done_valid(dv_a), .done_timeout(dt_a)
    );

    nand_cmd_seq #(.T_CS(B_CS), .T_CYC(B_CYC), .T_WB(B_WB), .TIMEOUT(B_TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(ready_b),
        .req_chip(req_chip), .req_cmd1(req_cmd1), .req_naddr(req_naddr), .req_addr(req_addr),
        .req_has_cmd2(req_has_cmd2), .req_cmd2(req_cmd2), .req_wait_rb(req_wait_rb), .rb_n(rb_n),
        .cen(cen_b), .cle(cle_b), .ale(ale_b), .wrn(wrn_b), .wpn(wpn_b), .dq_out(dq_b),
        .dq_oe(oe_b), .done_valid(dv_b), .done_timeout(dt_b)
    );

    // Packed pin view: {cen, cle, ale, dq_oe, dq_out, done_valid, done_timeout, req_ready, wrn, wpn}
    assign obs_a = {cen_a, cle_a, ale_a, oe_a, dq_a, dv_a, dt_a, ready_a, wrn_a, wpn_a};
    assign obs_b = {cen_b, cle_b, ale_b, oe_b, dq_b, dv_b, dt_b, ready_b, wrn_b, wpn_b};
    assign obs   = sel ? obs_b : obs_a;

    function automatic logic [17:0] pins(input logic [1:0] c, input logic cl, input logic al,
                                         input logic oe, input logic [7:0] dq, input logic dv,
                                         input logic dt, input logic rdy, input logic wp);
        return {c, cl, al, oe, dq, dv, dt, rdy, 1'b1, wp};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // r: first cycle (counted from acceptance) where rb_n[chip] is high; abort_at: cycle to pulse reset.
    task automatic run_op(input string name, input logic s, input logic chip, input logic [7:0] c1,
                          input logic [2:0] na_raw, input logic [39:0] addr, input logic hc,
                          input logic [7:0] c2, input logic wr, input int r, input int abort_at);
        int tcs, tcyc, twb, to, na, nb, s_cmd, s_end, e, c, d, bi, done_at;
        logic tmo, is_addr;
        logic [7:0] bytes [7];
        logic [1:0] ce;
        logic [17:0] ev;
        logic [17:0] idle_vec, rst_vec;

        tcs  = s ? B_CS  : A_CS;
        tcyc = s ? B_CYC : A_CYC;
        twb  = s ? B_WB  : A_WB;
        to   = s ? B_TO  : A_TO;
        na   = (na_raw > 3'd5) ? 5 : int'(na_raw);
        bytes[0] = c1;
        for (int i = 0; i < na; i++) bytes[i + 1] = addr[8 * i +: 8];
        bytes[na + 1] = c2;
        nb    = 1 + na + int'(hc);
        s_cmd = 1 + tcs;
        s_end = s_cmd + tcyc * nb;
        tmo   = 1'b0;
        if (wr) begin
            e = s_end + twb;
            c = (r + 2 > e) ? r + 2 : e;
            if (c - e + 1 > to) begin
                d   = e + to;
                tmo = 1'b1;
            end else begin
                d = c + 1;
            end
        end else begin
            d = s_end;
        end
        ce = 2'b11;
        ce[chip] = 1'b0;
        idle_vec = pins(2'b11, 0, 0, 0, 8'h00, 0, 0, 1, 1);
        rst_vec  = pins(2'b11, 0, 0, 0, 8'h00, 0, 0, 1, 0);

        @(posedge clk); #1;
        sel = s; req_valid = 1'b1; req_chip = chip; req_cmd1 = c1; req_naddr = na_raw;
        req_addr = addr; req_has_cmd2 = hc; req_cmd2 = c2; req_wait_rb = wr;
        rb_n = 4'($urandom);
        rb_n[chip] = (r <= 0);
        @(negedge clk);
        check($sformatf("%s c0", name), obs, idle_vec);

        done_at = -1;
        for (int k = 1; k <= d; k++) begin
            @(posedge clk); #1;
            req_valid  = 1'b0;
            rb_n[chip] = (k >= r);
            if (k == abort_at) rst_n = 1'b0;
            @(negedge clk);
            if (k == abort_at) begin
                check($sformatf("%s abort", name), obs, rst_vec);
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                check($sformatf("%s wpn_lo", name), obs, rst_vec);
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    check($sformatf("%s post_abort%0d", name, j), obs, idle_vec);
                end
                break;
            end
            if (obs[4]) done_at = k;
            if (k == d) begin
                ev = pins(2'b11, 0, 0, 0, 8'h00, 1, tmo, 0, 1);
            end else if (k >= s_cmd && k < s_end) begin
                bi      = (k - s_cmd) / tcyc;
                is_addr = (bi >= 1) && (bi <= na);
                ev = pins(ce, !is_addr, is_addr, 1, bytes[bi], 0, 0, 0, 1);
            end else begin
                ev = pins(ce, 0, 0, 0, 8'h00, 0, 0, 0, 1);
            end
            check($sformatf("%s c%0d", name, k), obs, ev);
        end
        if (abort_at > d) check($sformatf("%s done_cyc", name), done_at, d);
    endtask

    initial begin
        logic        rs, rc, rhc, rwr;
        logic [2:0]  rna;
        logic [39:0] raddr;
        int          rr;

        repeat (3) @(negedge clk);
        check("rst_a", obs_a, pins(2'b11, 0, 0, 0, 8'h00, 0, 0, 1, 0));
        check("rst_b", obs_b, pins(2'b11, 0, 0, 0, 8'h00, 0, 0, 1, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("wpn_hold", obs_a, pins(2'b11, 0, 0, 0, 8'h00, 0, 0, 1, 0));
        @(negedge clk);
        check("wpn_rise", obs_a, pins(2'b11, 0, 0, 0, 8'h00, 0, 0, 1, 1));

        run_op("page_read", 1'b0, 1'b0, OP_READ1, 3'd5, 40'h0504030201, 1'b1, OP_READ2, 1'b1, 50, NEVER);
        run_op("reset_cmd", 1'b0, 1'b1, OP_RESET, 3'd0, 40'h0, 1'b0, 8'h00, 1'b0, NEVER, NEVER);
        run_op("timeout", 1'b1, 1'b0, OP_ERASE1, 3'd3, 40'h00_0000_A1B2, 1'b1, OP_ERASE2, 1'b1, NEVER, NEVER);
        run_op("clamp", 1'b1, 1'b1, OP_PROG1, 3'd7, 40'hC5C4C3C2C1, 1'b0, 8'h00, 1'b1, 1, NEVER);
        run_op("abort", 1'b0, 1'b0, OP_READ1, 3'd5, 40'h1122334455, 1'b1, OP_READ2, 1'b1, 40, 5);
        run_op("status", 1'b0, 1'b1, OP_READ_STATUS, 3'd0, 40'h0, 1'b0, 8'h00, 1'b0, NEVER, NEVER);
        run_op("prog_b2b", 1'b1, 1'b0, OP_PROG1, 3'd5, 40'hFFEEDDCCBB, 1'b1, OP_PROG2, 1'b1, 30, NEVER);

        for (int n = 0; n < 24; n++) begin
            rs    = 1'($urandom);
            rc    = 1'($urandom);
            rna   = 3'($urandom_range(0, 7));
            raddr = {8'($urandom), 32'($urandom)};
            rhc   = 1'($urandom);
            rwr   = 1'($urandom);
            if (rs && ($urandom_range(0, 3) == 0)) rr = NEVER;
            else                                   rr = $urandom_range(0, 90);
            run_op($sformatf("rnd%0d", n), rs, rc, 8'($urandom), rna, raddr, rhc, 8'($urandom), rwr, rr, NEVER);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
